ddr_user_responder: RTL and testbench



---
 rtl/ddr_user_responder.sv | 196 +++++++++++++++++++
 tb/tb_ddr_user_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_user_responder.sv
// ddr_user_responder
// Responder for the DDR user command interface, backed by a 256 x 16 array.
// A single accepted command runs the activate / burst / recovery / precharge
// sequence. BUSY is high from the accepting edge until the edge that returns
// the FSM to IDLE. After a read, the read register is driven onto DATA_IN
// until the next command is accepted.
module ddr_user_responder #(
    parameter int BURST_LENGTH = 2,
    parameter int T_RCD        = 2,
    parameter int CAS_LAT      = 2,
    parameter int T_WR         = 2,
    parameter int T_RP         = 2
) (
    input  logic                       SYS_CLK_100M,
    input  logic                       RST,
    input  logic [1:0]                 BA_IN,
    input  logic [12:0]                ADDR_ROW_IN,
    input  logic [9:0]                 ADDR_COL_IN,
    inout  wire  [16*BURST_LENGTH-1:0] DATA_IN,
    input  logic                       WRITE,
    input  logic                       READ,
    input  logic [3:0]                 WRITE_LENGTH,
    output logic                       BUSY
);

    localparam int BL    = BURST_LENGTH;
    localparam int DW    = 16 * BL;
    localparam int KW    = (BL > 1) ? $clog2(BL) : 1;
    localparam int CNT_W = 16;

    // A timing value of zero still occupies one cycle of its state.
    localparam int RCD_CYC = (T_RCD   < 1) ? 1 : T_RCD;
    localparam int CAS_CYC = (CAS_LAT < 1) ? 1 : CAS_LAT;
    localparam int WR_CYC  = (T_WR    < 1) ? 1 : T_WR;
    localparam int RP_CYC  = (T_RP    < 1) ? 1 : T_RP;

    localparam logic [3:0] BL_MASK = 4'(BL - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACTIVATE,
        WR_BURST,
        WR_RECOVER,
        RD_LATENCY,
        RD_BURST,
        PRECHARGE
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] dur_m1;
    logic             last_cycle;
    logic             accept;

    // Command captured at acceptance
    logic [1:0]       ba_reg;
    logic [1:0]       row_reg;
    logic [3:0]       col_reg;
    logic [3:0]       len_reg;
    logic             is_wr_reg;
    logic [DW-1:0]    wdata_reg;

    // Array, read register and bus drive
    logic [15:0]      mem [256];
    logic [15:0]      wdata_words [BL];
    logic [15:0]      rd_words_reg [BL];
    logic             drive_reg;

    logic [KW-1:0]    word_sel;
    logic [3:0]       col_k;
    logic [7:0]       burst_idx;
    logic             wr_en;
    logic             rd_load;

    // Only the low address bits select array locations.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^{ADDR_ROW_IN[12:2], ADDR_COL_IN[9:4]};

    assign accept = (state_reg == IDLE) && (WRITE || READ);
    assign BUSY   = (state_reg != IDLE);

    // Per-state residency minus one, used to detect the last cycle of a state.
    always_comb begin
        dur_m1 = '0;
        case (state_reg)
            ACTIVATE:           dur_m1 = CNT_W'(RCD_CYC - 1);
            WR_BURST, RD_BURST: dur_m1 = CNT_W'(BL - 1);
            WR_RECOVER:         dur_m1 = CNT_W'(WR_CYC - 1);
            RD_LATENCY:         dur_m1 = CNT_W'(CAS_CYC - 1);
            PRECHARGE:          dur_m1 = CNT_W'(RP_CYC - 1);
            default:            dur_m1 = '0;
        endcase
    end

    assign last_cycle = (cnt_reg == dur_m1);

    // Next-state and cycle-counter logic; the counter restarts in every state.
    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        case (state_reg)
            IDLE:       if (accept)     state_next = ACTIVATE;
            ACTIVATE:   if (last_cycle) state_next = is_wr_reg ? WR_BURST : RD_LATENCY;
            WR_BURST:   if (last_cycle) state_next = WR_RECOVER;
            WR_RECOVER: if (last_cycle) state_next = PRECHARGE;
            RD_LATENCY: if (last_cycle) state_next = RD_BURST;
            RD_BURST:   if (last_cycle) state_next = PRECHARGE;
            PRECHARGE:  if (last_cycle) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
        if (state_reg != IDLE && !last_cycle) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge SYS_CLK_100M or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Capture address, length, direction and write data on the accepting edge.
    // Write wins when both requests are high.
    always_ff @(posedge SYS_CLK_100M or posedge RST) begin
        if (RST) begin
            ba_reg    <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            len_reg   <= '0;
            is_wr_reg <= 1'b0;
            wdata_reg <= '0;
        end else if (accept) begin
            ba_reg    <= BA_IN;
            row_reg   <= ADDR_ROW_IN[1:0];
            col_reg   <= ADDR_COL_IN[3:0];
            len_reg   <= WRITE_LENGTH;
            is_wr_reg <= WRITE;
            wdata_reg <= DATA_IN;
        end
    end

    // Burst word k wraps sequentially inside the aligned burst block.
    assign word_sel  = cnt_reg[KW-1:0];
    assign col_k     = (col_reg & ~BL_MASK) | ((col_reg + 4'(word_sel)) & BL_MASK);
    assign burst_idx = {ba_reg, row_reg, col_k};

    assign wr_en   = (state_reg == WR_BURST) &&
                     (cnt_reg < CNT_W'(len_reg)) && (cnt_reg < CNT_W'(BL));
    assign rd_load = (state_reg == RD_BURST);

    // Unpack the latched write data and drive the bus from the read register.
    genvar gi;
    generate
        for (gi = 0; gi < BL; gi++) begin : g_words
            assign wdata_words[gi]      = wdata_reg[16*gi +: 16];
            assign DATA_IN[16*gi +: 16] = drive_reg ? rd_words_reg[gi] : 16'hzzzz;
        end
    endgenerate

    // Array write port; contents survive reset.
    always_ff @(posedge SYS_CLK_100M) begin
        if (wr_en) begin
            mem[burst_idx] <= wdata_words[word_sel];
        end
    end

    // Registered array read into the read register, one slot per burst cycle.
    always_ff @(posedge SYS_CLK_100M or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < BL; i++) begin
                rd_words_reg[i] <= '0;
            end
        end else if (rd_load) begin
            rd_words_reg[word_sel] <= mem[burst_idx];
        end
    end

    // Bus ownership: take it when a read returns to IDLE, drop it on the next accept.
    always_ff @(posedge SYS_CLK_100M or posedge RST) begin
        if (RST) begin
            drive_reg <= 1'b0;
        end else if (accept) begin
            drive_reg <= 1'b0;
        end else if (state_reg == PRECHARGE && last_cycle && !is_wr_reg) begin
            drive_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr_user_responder.sv
// tb_ddr_user_responder
// Scenario tasks drive commands and compare BUSY length and DATA_IN contents.
// Expected read data is queued when a read is issued and popped when BUSY falls.
module tb_ddr_user_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ba = '0;
    logic [12:0] row = '0;
    logic [9:0]  col = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [3:0]  wlen = '0;
    logic        busy;
    logic [31:0] tb_drv = '0;
    logic        tb_drv_en = 1'b0;
    wire  [31:0] data_bus;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] exp_q [$];

    assign data_bus = tb_drv_en ? tb_drv : 32'bz;

    always #5 clk = ~clk;

    ddr_user_responder #(
        .BURST_LENGTH(2),
        .T_RCD(2),
        .CAS_LAT(2),
        .T_WR(2),
        .T_RP(2)
    ) dut (
        .SYS_CLK_100M(clk),
        .RST(rst),
        .BA_IN(ba),
        .ADDR_ROW_IN(row),
        .ADDR_COL_IN(col),
        .DATA_IN(data_bus),
        .WRITE(write),
        .READ(read),
        .WRITE_LENGTH(wlen),
        .BUSY(busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issue one command, count BUSY cycles, sample the bus while busy and after.
    task automatic run_cmd(input logic w, input logic r, input logic [1:0] b,
                           input logic [12:0] rw, input logic [9:0] c,
                           input logic [31:0] d, input logic [3:0] len,
                           output int busy_cyc, output logic [31:0] mid_bus,
                           output logic [31:0] end_bus);
        @(negedge clk);
        ba = b; row = rw; col = c; wlen = len; write = w; read = r;
        tb_drv = d;
        tb_drv_en = w;
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0;
        tb_drv = w ? ~d : 32'h0;
        tb_drv_en = 1'b1;
        #1 mid_bus = data_bus;
        busy_cyc = 0;
        while (busy === 1'b1 && busy_cyc < 50) begin
            @(posedge clk); #1;
            busy_cyc++;
        end
        if (r && !w) tb_drv_en = 1'b0;
        else tb_drv = 32'h0;
        #1 end_bus = data_bus;
        $display("cmd w=%0d r=%0d ba=%0d row=%0h col=%0h len=%0d busy_cycles=%0d bus_end=%h",
                 w, r, b, rw, c, len, busy_cyc, end_bus);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        tb_drv_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; write = 1'b0; read = 1'b0;
        tb_drv = 32'h0; tb_drv_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (data_bus !== 32'h0) $display("FAIL reset_bus_released: got %h expected 00000000", data_bus);
        else pass_cnt++;
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_write_read();
        int bc; logic [31:0] mb, eb, exp_v;
        run_cmd(1'b1, 1'b0, 2'd1, 13'd0, 10'd4, 32'hBEEF_1234, 4'd2, bc, mb, eb);
        total_cnt++;
        if (bc !== 8) $display("FAIL wr_busy_len: got %0d expected 8", bc);
        else pass_cnt++;
        total_cnt++;
        if (mb !== ~32'hBEEF_1234) $display("FAIL wr_bus_released: got %h expected %h", mb, ~32'hBEEF_1234);
        else pass_cnt++;

        exp_q.push_back(32'hBEEF_1234);
        run_cmd(1'b0, 1'b1, 2'd1, 13'd0, 10'd4, 32'h0, 4'd0, bc, mb, eb);
        total_cnt++;
        if (bc !== 8) $display("FAIL rd_busy_len: got %0d expected 8", bc);
        else pass_cnt++;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (eb !== exp_v) $display("FAIL rd_data: got %h expected %h", eb, exp_v);
        else pass_cnt++;

        // Upper row/column bits do not select array locations.
        exp_q.push_back(32'hBEEF_1234);
        run_cmd(1'b0, 1'b1, 2'd1, 13'h1004, 10'h3F4, 32'h0, 4'd0, bc, mb, eb);
        total_cnt++;
        if (mb !== 32'h0) $display("FAIL rd_bus_dropped_on_accept: got %h expected 00000000", mb);
        else pass_cnt++;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (eb !== exp_v) $display("FAIL rd_high_addr_ignored: got %h expected %h", eb, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_zero_length();
        int bc; logic [31:0] mb, eb, exp_v;
        pulse_reset();
        run_cmd(1'b1, 1'b0, 2'd1, 13'd0, 10'd4, 32'h7777_8888, 4'd0, bc, mb, eb);
        total_cnt++;
        if (bc !== 8) $display("FAIL len0_busy_len: got %0d expected 8", bc);
        else pass_cnt++;
        run_cmd(1'b1, 1'b0, 2'd0, 13'd2, 10'd6, 32'h9999_6666, 4'd9, bc, mb, eb);
        exp_q.push_back(32'hBEEF_1234);
        run_cmd(1'b0, 1'b1, 2'd1, 13'd0, 10'd4, 32'h0, 4'd0, bc, mb, eb);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (eb !== exp_v) $display("FAIL len0_no_commit: got %h expected %h", eb, exp_v);
        else pass_cnt++;
        exp_q.push_back(32'h9999_6666);
        run_cmd(1'b0, 1'b1, 2'd0, 13'd2, 10'd6, 32'h0, 4'd0, bc, mb, eb);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (eb !== exp_v) $display("FAIL len_over_bl: got %h expected %h", eb, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int bc; logic [31:0] mb, eb, exp_v;
        pulse_reset();
        run_cmd(1'b1, 1'b0, 2'd0, 13'd1, 10'd5, 32'hAAAA_5555, 4'd2, bc, mb, eb);
        exp_q.push_back(32'h5555_AAAA);
        run_cmd(1'b0, 1'b1, 2'd0, 13'd1, 10'd4, 32'h0, 4'd0, bc, mb, eb);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (eb !== exp_v) $display("FAIL wrap_read_col4: got %h expected %h", eb, exp_v);
        else pass_cnt++;
        exp_q.push_back(32'hAAAA_5555);
        run_cmd(1'b0, 1'b1, 2'd0, 13'd1, 10'd5, 32'h0, 4'd0, bc, mb, eb);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (eb !== exp_v) $display("FAIL wrap_read_col5: got %h expected %h", eb, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_overwrite();
        int bc; logic [31:0] mb, eb, exp_v;
        pulse_reset();
        run_cmd(1'b1, 1'b0, 2'd2, 13'd1, 10'd8, 32'h1111_2222, 4'd2, bc, mb, eb);
        run_cmd(1'b1, 1'b0, 2'd2, 13'd1, 10'd8, 32'h3333_4444, 4'd1, bc, mb, eb);
        exp_q.push_back(32'h1111_4444);
        run_cmd(1'b0, 1'b1, 2'd2, 13'd1, 10'd8, 32'h0, 4'd0, bc, mb, eb);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (eb !== exp_v) $display("FAIL partial_overwrite: got %h expected %h", eb, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_ignored_read();
        int bc; int extra; logic [31:0] mb, eb, exp_v;
        pulse_reset();
        @(negedge clk);
        ba = 2'd3; row = 13'd3; col = 10'd2; wlen = 4'd2; write = 1'b1; read = 1'b0;
        tb_drv = 32'h0F0F_F0F0; tb_drv_en = 1'b1;
        @(posedge clk); #1;
        write = 1'b0; tb_drv = 32'h0;
        bc = 0;
        while (busy === 1'b1 && bc < 50) begin
            read = (bc == 1);
            @(posedge clk); #1;
            bc++;
        end
        read = 1'b0;
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (busy !== 1'b0) extra++;
        end
        $display("cmd write with read pulse busy_cycles=%0d busy_after=%0d", bc, extra);
        total_cnt++;
        if (bc !== 8) $display("FAIL ignored_read_busy_len: got %0d expected 8", bc);
        else pass_cnt++;
        total_cnt++;
        if (extra !== 0) $display("FAIL ignored_read_no_queue: got %0d busy cycles expected 0", extra);
        else pass_cnt++;
        exp_q.push_back(32'h0F0F_F0F0);
        run_cmd(1'b0, 1'b1, 2'd3, 13'd3, 10'd2, 32'h0, 4'd0, bc, mb, eb);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (eb !== exp_v) $display("FAIL ignored_read_data: got %h expected %h", eb, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_write_and_read();
        int bc; logic [31:0] mb, eb, exp_v;
        pulse_reset();
        run_cmd(1'b1, 1'b1, 2'd3, 13'd2, 10'd0, 32'hCAFE_F00D, 4'd2, bc, mb, eb);
        total_cnt++;
        if (bc !== 8) $display("FAIL both_busy_len: got %0d expected 8", bc);
        else pass_cnt++;
        total_cnt++;
        if (eb !== 32'h0) $display("FAIL both_no_read_drive: got %h expected 00000000", eb);
        else pass_cnt++;
        exp_q.push_back(32'hCAFE_F00D);
        run_cmd(1'b0, 1'b1, 2'd3, 13'd2, 10'd0, 32'h0, 4'd0, bc, mb, eb);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (eb !== exp_v) $display("FAIL both_write_committed: got %h expected %h", eb, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_read();
        int bc; logic [31:0] mb, eb, exp_v;
        @(negedge clk);
        ba = 2'd1; row = 13'd0; col = 10'd4; read = 1'b1; tb_drv_en = 1'b0;
        @(posedge clk); #1;
        read = 1'b0; tb_drv = 32'h0; tb_drv_en = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        $display("reset asserted mid-read busy=%b bus=%h", busy, data_bus);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL midread_rst_busy: got %b expected 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (data_bus !== 32'h0) $display("FAIL midread_rst_bus: got %h expected 00000000", data_bus);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(32'hBEEF_1234);
        run_cmd(1'b0, 1'b1, 2'd1, 13'd0, 10'd4, 32'h0, 4'd0, bc, mb, eb);
        total_cnt++;
        if (bc !== 8) $display("FAIL after_rst_busy_len: got %0d expected 8", bc);
        else pass_cnt++;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (eb !== exp_v) $display("FAIL array_kept_over_reset: got %h expected %h", eb, exp_v);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_length();
        test_wrap();
        test_overwrite();
        test_ignored_read();
        test_write_and_read();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
